// File: rtl/spine_port_arbiter.sv
// spine_port_arbiter: round-robin packet-lock arbiter for one spine output port.
// Optional stall watchdog enabled by defining SPINE_ARB_TIMEOUT_EN.
module spine_port_arbiter #(
    parameter int N_IN    = 11,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] req,
    input  logic [N_IN-1:0] last,
    input  logic            out_ready,
    output logic [N_IN-1:0] grant,
    output logic [3:0]      granted_id,
    output logic            out_valid,
    output logic            out_last,
    output logic            busy,
    output logic            timeout_o
);
    localparam int PW = $clog2(N_IN);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr, pick, sel, sel_next;
    logic [PW:0]   j;
    logic          xfer, tail, fire;

    assign sel       = granted_id[PW-1:0];
    assign busy      = state == LOCK;
    assign out_valid = busy & req[sel];
    assign out_last  = out_valid & last[sel];
    assign xfer      = out_valid & out_ready;
    assign tail      = xfer & last[sel];
    assign sel_next  = (sel == PW'(N_IN - 1)) ? '0 : sel + 1'b1;

    // Scan offsets high to low so the nearest requester at or after rr_ptr wins.
    always_comb begin
        pick = '0;
        j    = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            j = {1'b0, rr_ptr} + (PW+1)'(k);
            j = (j >= (PW+1)'(N_IN)) ? j - (PW+1)'(N_IN) : j;
            pick = req[j[PW-1:0]] ? j[PW-1:0] : pick;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            granted_id <= '0;
            rr_ptr     <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                state      <= LOCK;
                grant      <= N_IN'(1) << pick;
                granted_id <= 4'(pick);
            end
        end else if (tail || fire) begin
            state      <= IDLE;
            grant      <= '0;
            granted_id <= '0;
            rr_ptr     <= sel_next;
        end
    end

`ifdef SPINE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    // cnt holds stalled cycles already seen; this cycle is the TIMEOUT-th.
    assign fire = busy & ~xfer & (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= fire;
            cnt       <= (!busy || xfer || fire) ? '0 : cnt + 1'b1;
        end
    end
`else
    assign fire      = 1'b0;
    assign timeout_o = 1'b0;
`endif
endmodule
